// File: rtl/fog_adc_emulator_if.sv
// ---------------------------------------------------------------------------
// fog_adc_emulator_if
// Bundles the FOG ADC emulator stimulus and sample-stream signals.
//   i_en          emulator enable
//   i_status      modulation half-period flag
//   i_dc_level    signed detector DC bias
//   i_rate        signed simulated Sagnac phase (LSB units)
//   i_gain        unsigned scale factor
//   i_glitch_amp  signed spike added to DC during a transition
//   i_glitch_len  glitch duration in cycles (0 disables)
//   o_adc_data    emulated signed ADC sample
//   o_valid       sample valid (latency aligned)
//   o_glitch      sample is a glitch sample (latency aligned)
//   o_cstate      FSM state
// Modports: master drives the stimulus, slave is the emulator.
// ---------------------------------------------------------------------------
interface fog_adc_emulator_if #(
    parameter int ADC_W = 14
);
    logic                    i_en;
    logic                    i_status;
    logic signed [ADC_W-1:0] i_dc_level;
    logic signed [15:0]      i_rate;
    logic [7:0]              i_gain;
    logic signed [ADC_W-1:0] i_glitch_amp;
    logic [7:0]              i_glitch_len;
    logic signed [ADC_W-1:0] o_adc_data;
    logic                    o_valid;
    logic                    o_glitch;
    logic [1:0]              o_cstate;

    modport master (
        output i_en, i_status, i_dc_level, i_rate, i_gain, i_glitch_amp, i_glitch_len,
        input  o_adc_data, o_valid, o_glitch, o_cstate
    );

    modport slave (
        input  i_en, i_status, i_dc_level, i_rate, i_gain, i_glitch_amp, i_glitch_len,
        output o_adc_data, o_valid, o_glitch, o_cstate
    );
endinterface

// File: rtl/fog_adc_emulator.sv
// ---------------------------------------------------------------------------
// fog_adc_emulator
// Closed-loop FOG photodetector model: turns the modulation half-period flag
// into a 14-bit signed ADC sample stream (DC bias, signed rate term,
// transition glitch, ADC pipeline latency of 1+ADC_LAT cycles).
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    fog_adc_emulator_if.slave (stimulus in, samples out)
// Optional feature: define ADC_EMU_NOISE_EN to add a 3-bit LFSR noise floor.
// ---------------------------------------------------------------------------
module fog_adc_emulator #(
    parameter int ADC_LAT    = 2,
    parameter int GAIN_SHIFT = 4,
    parameter int ADC_W      = 14
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fog_adc_emulator_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GLITCH = 2'd1,
        ST_STABLE = 2'd2
    } state_t;

    localparam logic signed [25:0] SAT_MAX = (26'sd1 <<< (ADC_W - 1)) - 26'sd1;
    localparam logic signed [25:0] SAT_MIN = -(26'sd1 <<< (ADC_W - 1));

    // Clamp a 26-bit intermediate into the ADC output range.
    function automatic logic [ADC_W-1:0] sat_fn(input logic signed [25:0] v);
        logic [ADC_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[ADC_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[ADC_W-1:0];
        end else begin
            r = v[ADC_W-1:0];
        end
        return r;
    endfunction

    state_t                  state_r;
    logic [7:0]              gcnt_r;
    logic                    status_d_r;
    logic [ADC_W-1:0]        cmp_data_r;
    logic                    cmp_valid_r;
    logic                    cmp_glitch_r;

    logic                    transition_s;
    logic                    glitch_sel_s;
    logic signed [24:0]      prod_s;
    logic signed [24:0]      term_s;
    logic signed [25:0]      dc_ext_s;
    logic signed [25:0]      amp_ext_s;
    logic signed [25:0]      term_ext_s;
    logic signed [25:0]      noise_ext_s;
    logic signed [25:0]      sum_s;

    assign transition_s = bus.i_en && (bus.i_status != status_d_r);
    assign prod_s       = 25'(bus.i_rate) * 25'($signed({1'b0, bus.i_gain}));
    assign term_s       = prod_s >>> GAIN_SHIFT;
    assign dc_ext_s     = {{(26 - ADC_W){bus.i_dc_level[ADC_W-1]}}, bus.i_dc_level};
    assign amp_ext_s    = {{(26 - ADC_W){bus.i_glitch_amp[ADC_W-1]}}, bus.i_glitch_amp};
    assign term_ext_s   = {term_s[24], term_s};

`ifdef ADC_EMU_NOISE_EN
    logic [15:0] lfsr_r;

    // Fibonacci LFSR x^16+x^14+x^13+x^11, free-running noise source.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign noise_ext_s = {{23{lfsr_r[2]}}, lfsr_r[2:0]};
`else
    assign noise_ext_s = 26'sd0;
`endif

    // Sample selection: the transition cycle itself already yields a glitch
    // sample, so GLITCH only needs gcnt more glitch cycles after it.
    always_comb begin
        glitch_sel_s = 1'b0;
        sum_s        = dc_ext_s;
        if (transition_s) begin
            glitch_sel_s = (bus.i_glitch_len != 8'd0);
        end else begin
            glitch_sel_s = (state_r == ST_GLITCH) && (gcnt_r != 8'd0);
        end
        if (glitch_sel_s) begin
            sum_s = dc_ext_s + amp_ext_s + noise_ext_s;
        end else if (bus.i_status) begin
            sum_s = dc_ext_s - term_ext_s + noise_ext_s;
        end else begin
            sum_s = dc_ext_s + term_ext_s + noise_ext_s;
        end
    end

    // Mode FSM with glitch counter and status history.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            gcnt_r     <= 8'd0;
            status_d_r <= 1'b0;
        end else begin
            status_d_r <= bus.i_status;
            if (!bus.i_en) begin
                state_r <= ST_IDLE;
                gcnt_r  <= 8'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_STABLE;
                    end
                    ST_STABLE: begin
                        if (transition_s && (bus.i_glitch_len != 8'd0)) begin
                            state_r <= ST_GLITCH;
                            gcnt_r  <= bus.i_glitch_len - 8'd1;
                        end else begin
                            state_r <= ST_STABLE;
                        end
                    end
                    ST_GLITCH: begin
                        if (transition_s) begin
                            if (bus.i_glitch_len != 8'd0) begin
                                gcnt_r <= bus.i_glitch_len - 8'd1;
                            end else begin
                                state_r <= ST_STABLE;
                            end
                        end else if (gcnt_r == 8'd0) begin
                            state_r <= ST_STABLE;
                        end else begin
                            gcnt_r <= gcnt_r - 8'd1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        gcnt_r  <= 8'd0;
                    end
                endcase
            end
        end
    end

    // Compute register: one saturated sample per cycle, zero/invalid in IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cmp_data_r   <= {ADC_W{1'b0}};
            cmp_valid_r  <= 1'b0;
            cmp_glitch_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            cmp_data_r   <= {ADC_W{1'b0}};
            cmp_valid_r  <= 1'b0;
            cmp_glitch_r <= 1'b0;
        end else begin
            cmp_data_r   <= sat_fn(sum_s);
            cmp_valid_r  <= 1'b1;
            cmp_glitch_r <= glitch_sel_s;
        end
    end

    assign bus.o_cstate = state_r;

    generate
        if (ADC_LAT == 0) begin : g_no_pipe
            assign bus.o_adc_data = cmp_data_r;
            assign bus.o_valid    = cmp_valid_r;
            assign bus.o_glitch   = cmp_glitch_r;
        end else begin : g_pipe
            logic [ADC_W-1:0] pd_r [ADC_LAT];
            logic [ADC_LAT-1:0] pv_r;
            logic [ADC_LAT-1:0] pg_r;

            // ADC pipeline: data, valid and glitch flag move together.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < ADC_LAT; i++) begin
                        pd_r[i] <= {ADC_W{1'b0}};
                    end
                    pv_r <= {ADC_LAT{1'b0}};
                    pg_r <= {ADC_LAT{1'b0}};
                end else begin
                    pd_r[0] <= cmp_data_r;
                    pv_r[0] <= cmp_valid_r;
                    pg_r[0] <= cmp_glitch_r;
                    for (int i = 1; i < ADC_LAT; i++) begin
                        pd_r[i] <= pd_r[i-1];
                        pv_r[i] <= pv_r[i-1];
                        pg_r[i] <= pg_r[i-1];
                    end
                end
            end

            assign bus.o_adc_data = pd_r[ADC_LAT-1];
            assign bus.o_valid    = pv_r[ADC_LAT-1];
            assign bus.o_glitch   = pg_r[ADC_LAT-1];
        end
    endgenerate
endmodule
